// File: rtl/divide_pipe_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : divide_pipe_param
// Description : Fully pipelined unsigned restoring divider. One quotient bit
//               per stage (MSB first), QW stages between an input register
//               and an output register. Flags report divide-by-zero and
//               quotient overflow. Global stall freezes every register.
// Revision    : 1.0 - initial release
// ============================================================================
module divide_pipe_param #(
    parameter int DW = 64,
    parameter int VW = 32,
    parameter int QW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          in_valid,
    input  logic [DW-1:0] a,
    input  logic [VW-1:0] b,
    output logic          out_valid,
    output logic [QW-1:0] quot,
    output logic [VW-1:0] rem,
    output logic          div0,
    output logic          ovf
);

    // Refuse to elaborate with a parameter set the datapath cannot support.
    if (QW < 1 || QW > DW || DW > QW + VW) begin : g_bad_params
        $error("divide_pipe_param: requires 1 <= QW <= DW <= QW+VW");
    end

    // Stage 0 is the input register; stage k holds the state after k
    // quotient bits. r_lq starts as the low dividend bits and, as each bit
    // is consumed from the top, the new quotient bit is shifted in at the
    // bottom, so after QW steps it holds the complete quotient.
    logic          r_v    [0:QW];
    logic [VW-1:0] r_prem [0:QW];
    logic [QW-1:0] r_lq   [0:QW];
    logic [VW-1:0] r_b    [0:QW];
    logic          r_div0 [0:QW];
    logic          r_ovf  [0:QW];

    logic          r_out_valid;
    logic [QW-1:0] r_quot;
    logic [VW-1:0] r_rem;
    logic          r_div0_out;
    logic          r_ovf_out;

    logic [VW-1:0] w_hi;
    logic          w_div0;
    logic          w_ovf;

    logic [VW-1:0] w_prem_nxt [1:QW];
    logic [QW-1:0] w_lq_nxt   [1:QW];

    // Upper dividend bits seed the partial remainder; none exist when DW == QW.
    if (DW > QW) begin : g_hi
        assign w_hi = VW'(a[DW-1:QW]);
    end else begin : g_no_hi
        assign w_hi = '0;
    end

    // With b == 0 every compare succeeds and subtracts nothing, so the
    // datapath itself yields quot = all ones and rem = a[VW-1:0].
    assign w_div0 = (b == '0);
    assign w_ovf  = !w_div0 && (w_hi >= b);

    // One restoring-division step per stage.
    for (genvar k = 1; k <= QW; k++) begin : g_stage
        logic [VW:0]   w_shift;
        logic [VW-1:0] w_diff;
        logic          w_ge;

        assign w_shift       = {r_prem[k-1], r_lq[k-1][QW-1]};
        assign w_ge          = (w_shift >= {1'b0, r_b[k-1]});
        // The difference is below the divisor, so its low VW bits are exact.
        assign w_diff        = w_shift[VW-1:0] - r_b[k-1];
        assign w_prem_nxt[k] = w_ge ? w_diff : w_shift[VW-1:0];
        assign w_lq_nxt[k]   = (r_lq[k-1] << 1) | QW'(w_ge);
    end

    // Pipeline registers: input stage plus all division stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k <= QW; k++) begin
                r_v[k]    <= 1'b0;
                r_prem[k] <= '0;
                r_lq[k]   <= '0;
                r_b[k]    <= '0;
                r_div0[k] <= 1'b0;
                r_ovf[k]  <= 1'b0;
            end
        end else if (!stall) begin
            r_v[0]    <= in_valid;
            r_prem[0] <= w_hi;
            r_lq[0]   <= a[QW-1:0];
            r_b[0]    <= b;
            r_div0[0] <= w_div0;
            r_ovf[0]  <= w_ovf;
            for (int k = 1; k <= QW; k++) begin
                r_v[k]    <= r_v[k-1];
                r_prem[k] <= w_prem_nxt[k];
                r_lq[k]   <= w_lq_nxt[k];
                r_b[k]    <= r_b[k-1];
                r_div0[k] <= r_div0[k-1];
                r_ovf[k]  <= r_ovf[k-1];
            end
        end
    end

    // Output register: force overflow results and zero everything on bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_div0_out  <= 1'b0;
            r_ovf_out   <= 1'b0;
        end else if (!stall) begin
            r_out_valid <= r_v[QW];
            if (r_v[QW]) begin
                r_quot     <= r_ovf[QW] ? '1 : r_lq[QW];
                r_rem      <= r_ovf[QW] ? '0 : r_prem[QW];
                r_div0_out <= r_div0[QW];
                r_ovf_out  <= r_ovf[QW];
            end else begin
                r_quot     <= '0;
                r_rem      <= '0;
                r_div0_out <= 1'b0;
                r_ovf_out  <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign quot      = r_quot;
    assign rem       = r_rem;
    assign div0      = r_div0_out;
    assign ovf       = r_ovf_out;

endmodule
`default_nettype wire
